// File: rtl/conv_dw_pkg.sv
// Shared definitions for the depthwise 3x3 convolution sequencer:
// field widths, edge (prov) encodings and the controller state enum.
package conv_dw_pkg;

  localparam int MAT_W  = 7;   // feature-map side
  localparam int MAT2_W = 13;  // side squared
  localparam int IDX_W  = 15;  // pixel index

  localparam logic [1:0] PROV_CENTER = 2'b00;
  localparam logic [1:0] PROV_RIGHT  = 2'b10;
  localparam logic [1:0] PROV_LEFT   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/conv_dw_scan.sv
// Raster scanner for one feature-map channel: row/col/pixel-index counters,
// edge decode from the column counter, and optional stride-2 stepping.
module conv_dw_scan
  import conv_dw_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_step,
  input  logic              i_stride2,
  input  logic [MAT_W-1:0]  i_matrix,
  input  logic [MAT2_W-1:0] i_matrix2,
  output logic [IDX_W-1:0]  o_i,
  output logic [1:0]        o_prov,
  output logic              o_last
);

  logic [MAT_W-1:0] r_row;
  logic [MAT_W-1:0] r_col;
  logic [IDX_W-1:0] r_i;

  logic [MAT_W-1:0] w_mat_m1;
  logic [MAT_W-1:0] w_mat_m2;
  logic [MAT_W-1:0] w_step;
  logic             w_row_end;
  logic             w_last;
  logic [IDX_W-1:0] w_next_row_i;

  assign w_mat_m1 = i_matrix - MAT_W'(1);
  assign w_mat_m2 = i_matrix - MAT_W'(2);
  assign w_step   = i_stride2 ? MAT_W'(2) : MAT_W'(1);

  // With stride 2 the row ends at the last even column, which may be
  // matrix-1 (odd side) or matrix-2 (even side).
  assign w_row_end = i_stride2 ? (r_col >= w_mat_m2) : (r_col == w_mat_m1);
  assign w_last    = i_stride2 ? (w_row_end && (r_row >= w_mat_m2))
                               : (r_i == IDX_W'(i_matrix2) - IDX_W'(1));

  // Start of the next scanned row: one pixel on for stride 1, two rows
  // down from the current row start for stride 2.
  assign w_next_row_i = i_stride2 ? (r_i - IDX_W'(r_col) + IDX_W'({i_matrix, 1'b0}))
                                  : (r_i + IDX_W'(1));

  // Counter advance on each issued pixel; wraps to pixel 0 after the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      r_row <= '0;
      r_col <= '0;
      r_i   <= '0;
    end else if (i_clear || (i_step && w_last)) begin
      r_row <= '0;
      r_col <= '0;
      r_i   <= '0;
    end else if (i_step) begin
      if (w_row_end) begin
        r_col <= '0;
        r_row <= r_row + w_step;
        r_i   <= w_next_row_i;
      end else begin
        r_col <= r_col + w_step;
        r_i   <= r_i + IDX_W'(w_step);
      end
    end
  end

  // Edge code from the true column position.
  always_comb begin
    // NOTE: default first so no path leaves o_prov unassigned (no latch).
    o_prov = PROV_CENTER;
    if (r_col == '0)           o_prov = PROV_LEFT;
    else if (r_col == w_mat_m1) o_prov = PROV_RIGHT;
  end

  assign o_i    = r_i;
  assign o_last = w_last;

endmodule

// File: rtl/conv_dw_ctrl.sv
// Sequencer for the depthwise 3x3 MAC: accepts a layer config, scans every
// channel's feature map in raster order, drives the MAC enable and tags each
// registered result with pixel index and channel.
// Optional build macro CONV_DW_CTRL_STRIDE2_EN adds cfg_stride2 (even
// rows/cols only); without it the stride is fixed at 1.
module conv_dw_ctrl
  import conv_dw_pkg::*;
#(
  parameter int CH_W       = 10,
  parameter int MAX_MATRIX = 90
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [MAT_W-1:0]  cfg_matrix,
  input  logic [CH_W-1:0]   cfg_channels,
`ifdef CONV_DW_CTRL_STRIDE2_EN
  input  logic              cfg_stride2,
`endif
  input  logic              out_ready,
  output logic [MAT_W-1:0]  matrix,
  output logic [MAT2_W-1:0] matrix2,
  output logic [IDX_W-1:0]  i,
  output logic [1:0]        prov,
  output logic [CH_W-1:0]   ch_idx,
  output logic              conv_DW_en,
  output logic              out_valid,
  output logic [IDX_W-1:0]  out_idx,
  output logic [CH_W-1:0]   out_ch,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  state_t            r_state;
  logic              r_busy;
  logic              r_done;
  logic              r_cfg_err;
  logic [MAT_W-1:0]  r_matrix;
  logic [MAT2_W-1:0] r_matrix2;
  logic [CH_W-1:0]   r_channels;
  logic [CH_W-1:0]   r_ch_idx;
  logic              r_out_valid;
  logic [IDX_W-1:0]  r_out_idx;
  logic [CH_W-1:0]   r_out_ch;

  logic              w_cfg_bad;
  logic              w_issue;
  logic              w_stride2;
  logic              w_last;
  logic [IDX_W-1:0]  w_i;
  logic [1:0]        w_prov;

`ifdef CONV_DW_CTRL_STRIDE2_EN
  logic              r_stride2;
  assign w_stride2 = r_stride2;
`else
  assign w_stride2 = 1'b0;
`endif

  assign w_cfg_bad = (cfg_matrix < MAT_W'(2)) ||
                     (cfg_matrix > MAT_W'(MAX_MATRIX)) ||
                     (cfg_channels == '0);

  // Issue is gated directly by out_ready so a stall holds the pixel in place.
  assign w_issue = (r_state == ST_RUN) && out_ready;

  conv_dw_scan u_scan (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (r_state == ST_SETUP),
    .i_step    (w_issue),
    .i_stride2 (w_stride2),
    .i_matrix  (r_matrix),
    .i_matrix2 (r_matrix2),
    .o_i       (w_i),
    .o_prov    (w_prov),
    .o_last    (w_last)
  );

  // Controller FSM with registered status outputs and latched configuration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_cfg_err  <= 1'b0;
      r_matrix   <= '0;
      r_matrix2  <= '0;
      r_channels <= '0;
      r_ch_idx   <= '0;
`ifdef CONV_DW_CTRL_STRIDE2_EN
      r_stride2  <= 1'b0;
`endif
    end else begin
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (w_cfg_bad) begin
              r_cfg_err <= 1'b1;
            end else begin
              r_matrix   <= cfg_matrix;
              r_channels <= cfg_channels;
`ifdef CONV_DW_CTRL_STRIDE2_EN
              r_stride2  <= cfg_stride2;
`endif
              r_busy     <= 1'b1;
              r_state    <= ST_SETUP;
            end
          end
        end
        ST_SETUP: begin
          r_matrix2 <= MAT2_W'(r_matrix) * MAT2_W'(r_matrix);
          r_ch_idx  <= '0;
          r_state   <= ST_RUN;
        end
        ST_RUN: begin
          if (w_issue && w_last) begin
            if (r_ch_idx == r_channels - CH_W'(1)) r_state <= ST_DRAIN;
            else                                    r_ch_idx <= r_ch_idx + CH_W'(1);
          end
        end
        ST_DRAIN: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= ST_DONE;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Result tagging: the MAC output registered one cycle after each issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
      r_out_ch    <= '0;
    end else begin
      r_out_valid <= w_issue;
      if (w_issue) begin
        r_out_idx <= w_i;
        r_out_ch  <= r_ch_idx;
      end
    end
  end

  assign matrix     = r_matrix;
  assign matrix2    = r_matrix2;
  assign i          = w_i;
  assign prov       = (r_state == ST_RUN) ? w_prov : PROV_CENTER;
  assign ch_idx     = r_ch_idx;
  assign conv_DW_en = w_issue;
  assign out_valid  = r_out_valid;
  assign out_idx    = r_out_idx;
  assign out_ch     = r_out_ch;
  assign busy       = r_busy;
  assign done       = r_done;
  assign cfg_err    = r_cfg_err;

endmodule

// File: tb/tb_conv_dw_ctrl.sv
// Self-checking bench for conv_dw_ctrl: a raster-order model builds the
// expected issue/result streams per job; a negedge monitor compares them.
module tb_conv_dw_ctrl;

  localparam int CH_W = 10;

  typedef struct {
    int i;
    int prov;
    int ch;
  } pix_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [6:0]      cfg_matrix = '0;
  logic [CH_W-1:0] cfg_channels = '0;
`ifdef CONV_DW_CTRL_STRIDE2_EN
  logic            cfg_stride2 = 1'b0;
`endif
  logic            out_ready = 1'b1;
  logic [6:0]      matrix;
  logic [12:0]     matrix2;
  logic [14:0]     i;
  logic [1:0]      prov;
  logic [CH_W-1:0] ch_idx;
  logic            conv_DW_en;
  logic            out_valid;
  logic [14:0]     out_idx;
  logic [CH_W-1:0] out_ch;
  logic            busy;
  logic            done;
  logic            cfg_err;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  bit   checking = 1'b0;
  bit   job_active = 1'b0;
  int   stall_mode = 0;
  int   cur_m = 0;
  int   n_issue = 0;
  int   n_res = 0;
  int   done_cnt = 0;
  int   err_cnt = 0;
  int   last_valid_cyc = 0;
  pix_t exp_issue[$];
  pix_t exp_res[$];

  conv_dw_ctrl #(.CH_W(CH_W), .MAX_MATRIX(90)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .cfg_matrix   (cfg_matrix),
    .cfg_channels (cfg_channels),
`ifdef CONV_DW_CTRL_STRIDE2_EN
    .cfg_stride2  (cfg_stride2),
`endif
    .out_ready    (out_ready),
    .matrix       (matrix),
    .matrix2      (matrix2),
    .i            (i),
    .prov         (prov),
    .ch_idx       (ch_idx),
    .conv_DW_en   (conv_DW_en),
    .out_valid    (out_valid),
    .out_idx      (out_idx),
    .out_ch       (out_ch),
    .busy         (busy),
    .done         (done),
    .cfg_err      (cfg_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected issue order: channels outer, rows, then columns, from the rules.
  task automatic build_model(input int m, input int c, input int s);
    int   step;
    pix_t p;
    step = (s != 0) ? 2 : 1;
    exp_issue.delete();
    exp_res.delete();
    for (int ch = 0; ch < c; ch++)
      for (int r = 0; r < m; r += step)
        for (int col = 0; col < m; col += step) begin
          p.i    = r * m + col;
          p.ch   = ch;
          p.prov = (col == 0) ? 3 : ((col == m - 1) ? 2 : 0);
          exp_issue.push_back(p);
          exp_res.push_back(p);
        end
  endtask

  // Per-cycle monitor comparing DUT against the model streams.
  always @(negedge clk) begin
    pix_t p;
    if (checking) begin
      if (conv_DW_en) begin
        n_issue++;
        check("en_needs_ready", out_ready, 1);
        check("busy_in_run", busy, 1);
        check("issue_expected", exp_issue.size() > 0, 1);
        if (exp_issue.size() > 0) begin
          p = exp_issue.pop_front();
          check("i", i, p.i);
          check("prov", prov, p.prov);
          check("ch_idx", ch_idx, p.ch);
          check("matrix", matrix, cur_m);
          check("matrix2", matrix2, cur_m * cur_m);
        end
      end else if (stall_mode == 2 && job_active && !out_ready) begin
        check("stall_i_hold", i, 5);
      end
      if (out_valid) begin
        n_res++;
        last_valid_cyc = cyc;
        check("result_expected", exp_res.size() > 0, 1);
        if (exp_res.size() > 0) begin
          p = exp_res.pop_front();
          check("out_idx", out_idx, p.i);
          check("out_ch", out_ch, p.ch);
        end
      end
      if (done) begin
        done_cnt++;
        check("done_after_last", cyc, last_valid_cyc + 1);
        check("busy_at_done", busy, 0);
        job_active = 1'b0;
      end else if (job_active) begin
        check("busy", busy, 1);
      end
      if (cfg_err) err_cnt++;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_en"}, conv_DW_en, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, cfg_err, 0);
    check({tag, "_i"}, i, 0);
    check({tag, "_prov"}, prov, 0);
    check({tag, "_ch"}, ch_idx, 0);
    check({tag, "_matrix"}, matrix, 0);
    check({tag, "_matrix2"}, matrix2, 0);
    check({tag, "_out_idx"}, out_idx, 0);
    check({tag, "_out_ch"}, out_ch, 0);
  endtask

  task automatic launch(input int m, input int c, input int s);
    @(posedge clk); #1;
    start        = 1'b1;
    cfg_matrix   = 7'(m);
    cfg_channels = CH_W'(c);
`ifdef CONV_DW_CTRL_STRIDE2_EN
    cfg_stride2  = (s != 0);
`endif
    @(posedge clk); #1;
    start      = 1'b0;
    job_active = 1'b1;
  endtask

  // mode 0: always ready; 1: random stalls; 2: 3-cycle stall after 5 issues.
  task automatic run_job(input int m, input int c, input int s, input int mode);
    int start_done, start_issue, start_res, budget, cycles, stall_left, side, total;
`ifndef CONV_DW_CTRL_STRIDE2_EN
    s = 0;
`endif
    build_model(m, c, s);
    cur_m       = m;
    stall_mode  = mode;
    start_done  = done_cnt;
    start_issue = n_issue;
    start_res   = n_res;
    launch(m, c, s);
    budget     = 4 * m * m * c + 100;
    cycles     = 0;
    stall_left = 3;
    while (done_cnt == start_done && cycles < budget) begin
      // A start while busy must be ignored, even an illegal one.
      if (cycles == 3) begin start = 1'b1; cfg_matrix = 7'd1; end
      else start = 1'b0;
      case (mode)
        1: out_ready = ($urandom_range(0, 3) != 0);
        2: if ((n_issue - start_issue) >= 5 && stall_left > 0) begin
             out_ready = 1'b0;
             stall_left--;
           end else out_ready = 1'b1;
        default: out_ready = 1'b1;
      endcase
      @(posedge clk); #1;
      cycles++;
    end
    start      = 1'b0;
    out_ready  = 1'b1;
    stall_mode = 0;
    side  = (s != 0) ? (m + 1) / 2 : m;
    total = c * side * side;
    check("job_done_once", done_cnt - start_done, 1);
    check("issue_count", n_issue - start_issue, total);
    check("result_count", n_res - start_res, total);
    check("issue_q_empty", exp_issue.size(), 0);
    check("result_q_empty", exp_res.size(), 0);
    exp_issue.delete();
    exp_res.delete();
    job_active = 1'b0;
  endtask

  task automatic reject(input int m, input int c);
    @(posedge clk); #1;
    start        = 1'b1;
    cfg_matrix   = 7'(m);
    cfg_channels = CH_W'(c);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("cfg_err_pulse", cfg_err, 1);
    check("busy_on_reject", busy, 0);
    @(negedge clk);
    check("cfg_err_one_cycle", cfg_err, 0);
    check("busy_after_reject", busy, 0);
  endtask

  initial begin
    int cycles, d0, e0;
`ifdef CONV_DW_CTRL_STRIDE2_EN
    int seq5[9] = '{0, 2, 4, 10, 12, 14, 20, 22, 24};
`endif

    #1;
    check_all_zero("reset");
    #21;
    rst_n    = 1'b1;
    checking = 1'b1;

    // Hand-computed pins on the model itself.
    build_model(4, 1, 0);
    check("model4_size", exp_issue.size(), 16);
    check("model4_prov3", exp_issue[3].prov, 2);
    check("model4_prov4", exp_issue[4].prov, 3);
    check("model4_prov5", exp_issue[5].prov, 0);
    build_model(3, 3, 0);
    check("model3_size", exp_issue.size(), 27);
    check("model3_i8", exp_issue[8].i, 8);
    check("model3_wrap_i", exp_issue[9].i, 0);
    check("model3_wrap_ch", exp_issue[9].ch, 1);
    exp_issue.delete();
    exp_res.delete();

    run_job(4, 1, 0, 0);
    run_job(3, 3, 0, 0);
    run_job(4, 1, 0, 2);

    e0 = err_cnt;
    reject(1, 1);
    reject(91, 1);
    reject(4, 0);
    check("cfg_err_pulses", err_cnt - e0, 3);

    // Abort mid-run at pixel 7 of an 8x8 map.
    build_model(8, 1, 0);
    cur_m = 8;
    launch(8, 1, 0);
    cycles = 0;
    while (!(conv_DW_en && i == 15'd7) && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    check("reach_i7", i, 7);
    #2;
    checking   = 1'b0;
    job_active = 1'b0;
    rst_n      = 1'b0;
    #1;
    check_all_zero("abort");
    exp_issue.delete();
    exp_res.delete();
    d0 = done_cnt;
    @(posedge clk); #3;
    rst_n    = 1'b1;
    checking = 1'b1;
    repeat (5) @(negedge clk);
    check("no_done_after_abort", done_cnt, d0);
    run_job(8, 2, 0, 1);

`ifdef CONV_DW_CTRL_STRIDE2_EN
    build_model(5, 1, 1);
    check("model5s_size", exp_issue.size(), 9);
    for (int k = 0; k < 9; k++) check("model5s_i", exp_issue[k].i, seq5[k]);
    check("model5s_prov2", exp_issue[2].prov, 2);
    run_job(5, 1, 1, 0);
    run_job(4, 2, 1, 1);
    run_job(2, 1, 1, 0);
`endif

    run_job(2, 2, 0, 1);
    for (int n = 0; n < 6; n++)
      run_job($urandom_range(2, 12), $urandom_range(1, 3), $urandom_range(0, 1), 1);
    run_job(90, 1, 0, 0);

    check("cfg_err_total", err_cnt, 3);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/conv_dw_ctrl.md
Name: conv_dw_ctrl

Overview:
- Sequencer for the depthwise 3x3 MAC unit (conv_DW).
- Scans one feature map per channel in raster order and drives the pixel index, edge code (prov), matrix/matrix2 and the MAC enable.
- Tags each registered MAC result with valid, pixel index and channel, and signals completion.
- Sits between the layer scheduler (start/config) and the feature/weight buffers plus the DW MAC.

Parameters:
- CH_W, 10, width of channel count and channel index.
- MAX_MATRIX, 90, largest legal feature-map side (matrix2 must fit 13 bits).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; accepted only in IDLE
- cfg_matrix  in  7  feature-map side, sampled on accepted start
- cfg_channels  in  CH_W  channel count, sampled on accepted start
- out_ready  in  1  downstream can take a result next cycle; issue stalls while low
- matrix  out  7  latched side, to MAC
- matrix2  out  13  matrix*matrix, to MAC
- i  out  15  current pixel index, to MAC and feature buffer
- prov  out  2  2'b11 left column, 2'b10 right column, 2'b00 otherwise
- ch_idx  out  CH_W  current channel, to weight buffer
- conv_DW_en  out  1  MAC enable, one pixel per cycle
- out_valid  out  1  MAC result Y1 valid this cycle
- out_idx  out  15  pixel index of the valid result
- out_ch  out  CH_W  channel of the valid result
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse after the last result
- cfg_err  out  1  one-cycle pulse when a start is rejected

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0. Reset mid-run aborts immediately. done is not asserted. A new start is required.
- States and transitions:
  - IDLE: on start, if cfg_matrix<2, cfg_matrix>MAX_MATRIX or cfg_channels==0, pulse cfg_err and stay in IDLE. Otherwise latch cfg_matrix and cfg_channels, go to SETUP, busy=1.
  - SETUP (1 cycle): register matrix2 = matrix*matrix (13 bits). Clear row/col/i/ch_idx. Go to RUN.
  - RUN: in a cycle with out_ready=1, conv_DW_en=1 and i, prov, ch_idx present the current pixel. Then advance: col+1, i+1.
    - At col==matrix-1: col=0, row+1.
    - At the last pixel (i==matrix2-1): i=0, row=0, ch_idx+1.
    - At the last pixel of channel cfg_channels-1: go to DRAIN.
    - In a cycle with out_ready=0: conv_DW_en=0 and i, prov, ch_idx hold.
  - DRAIN (1 cycle): the final result's out_valid is asserted. Go to DONE.
  - DONE (1 cycle): done=1, busy=0. Return to IDLE.
- Result latency:
  - out_valid(t+1) = conv_DW_en(t).
  - out_idx and out_ch are the i and ch_idx registered from cycle t.
  - Results come out in strict raster/channel order.
  - Downstream must accept every out_valid; out_ready only gates issue.
- prov is computed combinationally from the col counter, not from a divide of i. col==0 gives 11, col==matrix-1 gives 10.
- start while busy is ignored (no cfg_err).
- Simultaneous last-pixel issue and out_ready drop: the issue already happened and the transition to DRAIN still occurs.
- Total RUN issue cycles = cfg_channels*matrix2 plus the number of out_ready-low cycles.

Optional Feature:
- Macro: CONV_DW_CTRL_STRIDE2_EN.
- Defined:
  - Adds input cfg_stride2 (1 bit), sampled with start.
  - When cfg_stride2=1, RUN issues only pixels with even row and even col. col and row step by 2; a row end at col>=matrix-2 wraps. i advances accordingly (i+2, or to the start of row+2).
  - prov still reflects the true column.
  - Odd matrix includes the last column and row.
  - Results per channel = ceil(matrix/2)^2.
- Not defined: port absent; stride fixed at 1.

Decomposition:
- Shared package conv_dw_pkg:
  - prov encodings PROV_CENTER=2'b00, PROV_RIGHT=2'b10, PROV_LEFT=2'b11.
  - State enum.
  - Config widths (7, 13, 15).
- One natural sub-module, conv_dw_scan: row/col/i counters with the prov decode and stride stepping. conv_dw_ctrl keeps the FSM, handshake and result tagging.

Test Plan:
- matrix=4, channels=1, out_ready=1:
  - i runs 0..15 on 16 consecutive conv_DW_en cycles.
  - prov = 11,00,00,10 repeated.
  - out_valid 16 cycles, out_idx 0..15.
  - done exactly 2 cycles after the last out_valid-producing issue... one pulse after the final result.
- matrix=3, channels=3: ch_idx goes 0 (9 pixels), 1, 2; i wraps 8->0; 27 results, out_ch tags correct; matrix2=9.
- matrix=4, out_ready low for cycles 5-7 of RUN: conv_DW_en=0 and i holds at 5 for 3 cycles; the full sequence completes with 16 results, none dropped or duplicated.
- start with cfg_matrix=1, then 91, then channels=0: each gives one cfg_err pulse, busy stays 0, no conv_DW_en.
- rst_n low at i=7 of matrix=8: all outputs 0 asynchronously, no done; a new start restarts at i=0, ch=0.
- CONV_DW_CTRL_STRIDE2_EN, matrix=5, stride2=1: i sequence 0,2,4,10,12,14,20,22,24; prov 11,00,10 per row; 9 results.
